// File: rtl/multicycle_control.sv
// Multicycle MIPS control sequencer: a registered state walks each instruction
// through 3-5 steps and decodes the datapath selects/enables from it.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNE,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [3:0]       ALUOpFinal,
  output logic             Inm,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADDR = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_REXEC   = 4'd6;
  localparam logic [3:0] S_RWB     = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_JUMP    = 4'd9;
  localparam logic [3:0] S_IEXEC   = 4'd10;
  localparam logic [3:0] S_IWB     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  logic [3:0] state_nxt;
  logic [5:0] op_q;
  logic       retire;
  logic       decode_bad;

  function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ADDI: imm_alu_op = 4'b0010;
      OP_ANDI: imm_alu_op = 4'b0000;
      OP_ORI:  imm_alu_op = 4'b0001;
      OP_SLTI: imm_alu_op = 4'b0111;
      default: imm_alu_op = 4'b0000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      op_q        <= '0;
      instr_count <= '0;
      illegal_op  <= 1'b0;
    end else begin
      state      <= state_nxt;
      illegal_op <= decode_bad;
      if (state == S_DECODE) op_q <= opcode;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // DECODE branches on the live opcode because op_q only loads at its end
  always_comb begin
    state_nxt  = state;
    retire     = 1'b0;
    decode_bad = 1'b0;
    case (state)
      S_FETCH:   if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                      state_nxt = S_MEMADDR;
          OP_RTYPE:                          state_nxt = S_REXEC;
          OP_BEQ, OP_BNE:                    state_nxt = S_BRANCH;
          OP_J:                              state_nxt = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_nxt = S_IEXEC;
          default: begin
            state_nxt  = S_FETCH;
            decode_bad = 1'b1;
          end
        endcase
      end
      S_MEMADDR: state_nxt = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_nxt = S_MEMWB;
      S_MEMWR: begin
        if (mem_ready) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_REXEC:   state_nxt = S_RWB;
      S_IEXEC:   state_nxt = S_IWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      default:   state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    ALUOpFinal  = 4'b0000;
    Inm         = 1'b0;
    PCSource    = 2'b00;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE:  ALUSrcB = 2'b11;
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchNE    = (op_q == OP_BNE);
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_IEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUOp      = 2'b11;
        Inm        = 1'b1;
        ALUOpFinal = imm_alu_op(op_q);
      end
      S_IWB: begin
        RegWrite   = 1'b1;
        Inm        = 1'b1;
        ALUOpFinal = imm_alu_op(op_q);
      end
      default: ;
    endcase
    // Architectural writes are blocked while reset is held, even mid-instruction
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and checks decoded controls against hand-derived values.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, Inm, illegal_op;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  ALUOpFinal, state;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ALUOpFinal(ALUOpFinal), .Inm(Inm), .PCSource(PCSource), .state(state),
    .illegal_op(illegal_op), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
    #2;
    checks++;
    if (PCWrite !== 1'b0 || IRWrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_force_wr PCWrite=%b IRWrite=%b exp 0 0", PCWrite, IRWrite);
    end
    step(); step();
    checks++;
    if (state !== 4'd0 || instr_count !== 32'd0 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL reset_state state=%0d cnt=%0d ill=%b exp 0 0 0", state, instr_count, illegal_op);
    end
    rst = 1'b0;
  endtask

  task automatic test_rtype();
    logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic       exp_rw [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 6'b000000; mem_ready = 1'b1;
    #1;
    checks++;
    if (PCWrite !== 1'b1 || IRWrite !== 1'b1 || MemRead !== 1'b1 || ALUSrcB !== 2'b01) begin
      errors++;
      $display("FAIL fetch_ctl PCW=%b IRW=%b MR=%b SrcB=%b exp 1 1 1 01", PCWrite, IRWrite, MemRead, ALUSrcB);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state !== exp_st[i] || RegWrite !== exp_rw[i] || RegDst !== exp_rw[i]) begin
        errors++;
        $display("FAIL rtype_seq[%0d] state=%0d RegWrite=%b RegDst=%b exp %0d %b %b",
                 i, state, RegWrite, RegDst, exp_st[i], exp_rw[i], exp_rw[i]);
      end
      if (i == 2) begin
        checks++;
        if (ALUOp !== 2'b10 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00) begin
          errors++;
          $display("FAIL rexec_ctl ALUOp=%b SrcA=%b SrcB=%b exp 10 1 00", ALUOp, ALUSrcA, ALUSrcB);
        end
      end
      if (i < 4) step();
    end
    checks++;
    if (instr_count !== 32'd1) begin
      errors++;
      $display("FAIL rtype_count got %0d exp 1", instr_count);
    end
  endtask

  task automatic test_lw_wait();
    opcode = 6'b100011; mem_ready = 1'b1;
    step(); step();
    checks++;
    if (state !== 4'd2 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10 || ALUOp !== 2'b00) begin
      errors++;
      $display("FAIL memaddr state=%0d SrcA=%b SrcB=%b ALUOp=%b exp 2 1 10 00", state, ALUSrcA, ALUSrcB, ALUOp);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      checks++;
      if (state !== 4'd3 || MemRead !== 1'b1 || IorD !== 1'b1) begin
        errors++;
        $display("FAIL lw_hold[%0d] state=%0d MemRead=%b IorD=%b exp 3 1 1", i, state, MemRead, IorD);
      end
      step();
    end
    checks++;
    if (state !== 4'd4 || MemtoReg !== 1'b1 || RegWrite !== 1'b1 || RegDst !== 1'b0) begin
      errors++;
      $display("FAIL memwb state=%0d MemtoReg=%b RegWrite=%b RegDst=%b exp 4 1 1 0", state, MemtoReg, RegWrite, RegDst);
    end
    step();
    checks++;
    if (state !== 4'd0 || instr_count !== 32'd2) begin
      errors++;
      $display("FAIL lw_done state=%0d cnt=%0d exp 0 2", state, instr_count);
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops [2] = '{6'b000101, 6'b000100};
    logic       ne  [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k]; mem_ready = 1'b1;
      step(); step();
      checks++;
      if (state !== 4'd8 || PCWriteCond !== 1'b1 || PCSource !== 2'b01 ||
          ALUOp !== 2'b01 || BranchNE !== ne[k]) begin
        errors++;
        $display("FAIL branch[%0d] state=%0d PCWC=%b PCSrc=%b ALUOp=%b BNE=%b exp 8 1 01 01 %b",
                 k, state, PCWriteCond, PCSource, ALUOp, BranchNE, ne[k]);
      end
      step();
    end
    checks++;
    if (state !== 4'd0 || instr_count !== 32'd4) begin
      errors++;
      $display("FAIL branch_done state=%0d cnt=%0d exp 0 4", state, instr_count);
    end
  endtask

  task automatic test_imm();
    logic [5:0] ops [2] = '{6'b001010, 6'b001101};
    logic [3:0] fin [2] = '{4'b0111, 4'b0001};
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k]; mem_ready = 1'b1;
      step(); step();
      checks++;
      if (state !== 4'd10 || ALUOpFinal !== fin[k] || Inm !== 1'b1 || ALUOp !== 2'b11 || ALUSrcB !== 2'b10) begin
        errors++;
        $display("FAIL iexec[%0d] state=%0d Final=%b Inm=%b ALUOp=%b SrcB=%b exp 10 %b 1 11 10",
                 k, state, ALUOpFinal, Inm, ALUOp, ALUSrcB, fin[k]);
      end
      step();
      checks++;
      if (state !== 4'd11 || ALUOpFinal !== fin[k] || Inm !== 1'b1 || ALUOp !== 2'b00 ||
          RegWrite !== 1'b1 || RegDst !== 1'b0) begin
        errors++;
        $display("FAIL iwb[%0d] state=%0d Final=%b Inm=%b ALUOp=%b RW=%b RD=%b exp 11 %b 1 00 1 0",
                 k, state, ALUOpFinal, Inm, ALUOp, RegWrite, RegDst, fin[k]);
      end
      step();
      checks++;
      if (state !== 4'd0 || ALUOpFinal !== 4'b0000 || Inm !== 1'b0) begin
        errors++;
        $display("FAIL imm_done[%0d] state=%0d Final=%b Inm=%b exp 0 0000 0", k, state, ALUOpFinal, Inm);
      end
    end
  endtask

  task automatic test_jump();
    opcode = 6'b000010; mem_ready = 1'b1;
    step(); step();
    checks++;
    if (state !== 4'd9 || PCWrite !== 1'b1 || PCSource !== 2'b10) begin
      errors++;
      $display("FAIL jump state=%0d PCWrite=%b PCSource=%b exp 9 1 10", state, PCWrite, PCSource);
    end
    step();
    checks++;
    if (state !== 4'd0 || instr_count !== 32'd7) begin
      errors++;
      $display("FAIL jump_done state=%0d cnt=%0d exp 0 7", state, instr_count);
    end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111; mem_ready = 1'b1;
    step();
    checks++;
    if (state !== 4'd1 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL ill_decode state=%0d ill=%b exp 1 0", state, illegal_op);
    end
    mem_ready = 1'b0;
    step();
    #1;
    checks++;
    if (state !== 4'd0 || illegal_op !== 1'b1 || instr_count !== 32'd7) begin
      errors++;
      $display("FAIL ill_pulse state=%0d ill=%b cnt=%0d exp 0 1 7", state, illegal_op, instr_count);
    end
    checks++;
    if (IRWrite !== 1'b0 || PCWrite !== 1'b0 || MemRead !== 1'b1) begin
      errors++;
      $display("FAIL fetch_stall IRW=%b PCW=%b MR=%b exp 0 0 1", IRWrite, PCWrite, MemRead);
    end
    step();
    checks++;
    if (state !== 4'd0 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL ill_clear state=%0d ill=%b exp 0 0", state, illegal_op);
    end
  endtask

  task automatic test_sw_reset();
    opcode = 6'b101011; mem_ready = 1'b1;
    step(); step(); step();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 4'd5 || MemWrite !== 1'b1 || IorD !== 1'b1) begin
      errors++;
      $display("FAIL memwr state=%0d MemWrite=%b IorD=%b exp 5 1 1", state, MemWrite, IorD);
    end
    step();
    checks++;
    if (state !== 4'd5 || MemWrite !== 1'b1 || instr_count !== 32'd7) begin
      errors++;
      $display("FAIL memwr_hold state=%0d MemWrite=%b cnt=%0d exp 5 1 7", state, MemWrite, instr_count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL rst_force_mw MemWrite=%b exp 0", MemWrite);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || MemWrite !== 1'b0 || instr_count !== 32'd0) begin
      errors++;
      $display("FAIL rst_midinstr state=%0d MemWrite=%b cnt=%0d exp 0 0 0", state, MemWrite, instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_imm();
    test_jump();
    test_illegal();
    test_sw_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
